spgd_meas_sequencer: RTL and testbench

Sequencer for one SPGD metric measurement cycle. It drives the ADC averaging block and the dither (perturbation) control. Each cycle applies a +δ perturbation, waits for settling, and runs one averaging window to capture J+. It then repeats with −δ to capture J−, and outputs the signed metric difference ΔJ = J+ − J− to the gradient-update logic. The averager datapath sits outside this block; the sequencer only sequences it through its enable/done/data handshake.

---
 rtl/spgd_seq_pkg.sv | 29 ++
 rtl/spgd_meas_sequencer_if.sv | 35 +++
 rtl/seq_timer.sv | 36 +++
 rtl/spgd_meas_sequencer.sv | 152 +++++++++++++++
 tb/tb_spgd_meas_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spgd_seq_pkg.sv
// Shared definitions for the SPGD measurement sequencer: state encoding,
// default widths and a small parameter helper.
package spgd_seq_pkg;

   localparam int unsigned DEFAULT_ADC_WIDTH = 12;
   localparam int unsigned DEFAULT_CNT_WIDTH = 16;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SET_POS  = 3'd1;
   localparam logic [2:0] MEAS_POS = 3'd2;
   localparam logic [2:0] SET_NEG  = 3'd3;
   localparam logic [2:0] MEAS_NEG = 3'd4;
   localparam logic [2:0] RESULT   = 3'd5;

   typedef enum logic [2:0] {
      StIdle    = IDLE,
      StSetPos  = SET_POS,
      StMeasPos = MEAS_POS,
      StSetNeg  = SET_NEG,
      StMeasNeg = MEAS_NEG,
      StResult  = RESULT
   } seq_state_e;

   // A zero-length settle or timeout would never let the timer expire cleanly.
   function automatic int unsigned at_least_one(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

endpackage

// File: rtl/spgd_meas_sequencer_if.sv
// Handshake bundle between the sequencer, its controller, the averager and
// the dither drivers.
interface spgd_meas_sequencer_if
   import spgd_seq_pkg::*;
#(
   parameter int unsigned ADC_WIDTH = DEFAULT_ADC_WIDTH
);

   logic                 START;
   logic                 ABORT;
   logic                 AVG_DONE;
   logic [ADC_WIDTH-1:0] AVG_DATA;
   logic                 AVG_EN;
   logic                 PERTURB_POS;
   logic                 PERTURB_NEG;
   logic                 BUSY;
   logic [ADC_WIDTH-1:0] J_POS;
   logic [ADC_WIDTH-1:0] J_NEG;
   logic [ADC_WIDTH:0]   DELTA_J;
   logic                 RESULT_VALID;
   logic                 TIMEOUT_ERR;

   modport master (
      input  START, ABORT, AVG_DONE, AVG_DATA,
      output AVG_EN, PERTURB_POS, PERTURB_NEG, BUSY, J_POS, J_NEG, DELTA_J,
             RESULT_VALID, TIMEOUT_ERR
   );

   modport slave (
      output START, ABORT, AVG_DONE, AVG_DATA,
      input  AVG_EN, PERTURB_POS, PERTURB_NEG, BUSY, J_POS, J_NEG, DELTA_J,
             RESULT_VALID, TIMEOUT_ERR
   );

endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag; used for both settle delays and
// measurement timeouts.
module seq_timer
   import spgd_seq_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   output logic                 zero
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/spgd_meas_sequencer.sv
// One SPGD metric cycle: +delta settle/measure, -delta settle/measure, then
// publish DELTA_J = J_POS - J_NEG.
module spgd_meas_sequencer
   import spgd_seq_pkg::*;
#(
   parameter int unsigned ADC_WIDTH      = DEFAULT_ADC_WIDTH,
   parameter int unsigned SETTLE_CYCLES  = 64,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
   input logic                   CLK,
   input logic                   RST_N,
   spgd_meas_sequencer_if.master bus
);

   // The timer counts down to zero inclusive, so load one less than the length.
   localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD  = CNT_WIDTH'(at_least_one(SETTLE_CYCLES) - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(at_least_one(TIMEOUT_CYCLES) - 1);

   seq_state_e state_q, state_d;

   logic                 timer_load;
   logic [CNT_WIDTH-1:0] timer_load_val;
   logic                 timer_zero;

   logic [ADC_WIDTH-1:0] j_pos_q, j_pos_d;
   logic [ADC_WIDTH-1:0] j_neg_q, j_neg_d;
   logic [ADC_WIDTH:0]   delta_q, delta_d;
   logic                 timeout_err_q, timeout_err_d;
   logic                 avg_en_q, avg_en_d;
   logic                 perturb_pos_q, perturb_pos_d;
   logic                 perturb_neg_q, perturb_neg_d;
   logic                 busy_q, busy_d;
   logic                 result_valid_q, result_valid_d;

   seq_timer #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_timer (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .load     (timer_load),
      .load_val (timer_load_val),
      .zero     (timer_zero)
   );

   always_comb begin
      state_d       = state_q;
      j_pos_d       = j_pos_q;
      j_neg_d       = j_neg_q;
      delta_d       = delta_q;
      timeout_err_d = timeout_err_q;

      if (bus.ABORT) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.START) begin
                  state_d       = StSetPos;
                  timeout_err_d = 1'b0;
               end
            end
            StSetPos: begin
               if (timer_zero) state_d = StMeasPos;
            end
            StMeasPos: begin
               if (bus.AVG_DONE) begin
                  j_pos_d = bus.AVG_DATA;
                  state_d = StSetNeg;
               end else if (timer_zero) begin
                  state_d       = StIdle;
                  timeout_err_d = 1'b1;
               end
            end
            StSetNeg: begin
               if (timer_zero) state_d = StMeasNeg;
            end
            StMeasNeg: begin
               if (bus.AVG_DONE) begin
                  j_neg_d = bus.AVG_DATA;
                  // J_NEG lands this edge, so take the new sample straight from the bus.
                  delta_d = {j_pos_q[ADC_WIDTH-1], j_pos_q}
                          - {bus.AVG_DATA[ADC_WIDTH-1], bus.AVG_DATA};
                  state_d = StResult;
               end else if (timer_zero) begin
                  state_d       = StIdle;
                  timeout_err_d = 1'b1;
               end
            end
            StResult: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Reload the shared timer on every state change.
   always_comb begin
      timer_load     = (state_d != state_q);
      timer_load_val = ((state_d == StMeasPos) || (state_d == StMeasNeg)) ? TIMEOUT_LOAD
                                                                          : SETTLE_LOAD;
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      avg_en_d       = (state_d == StMeasPos) || (state_d == StMeasNeg);
      perturb_pos_d  = (state_d == StSetPos) || (state_d == StMeasPos);
      perturb_neg_d  = (state_d == StSetNeg) || (state_d == StMeasNeg);
      busy_d         = (state_d != StIdle);
      result_valid_d = (state_d == StResult);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q        <= StIdle;
         j_pos_q        <= '0;
         j_neg_q        <= '0;
         delta_q        <= '0;
         timeout_err_q  <= 1'b0;
         avg_en_q       <= 1'b0;
         perturb_pos_q  <= 1'b0;
         perturb_neg_q  <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         j_pos_q        <= j_pos_d;
         j_neg_q        <= j_neg_d;
         delta_q        <= delta_d;
         timeout_err_q  <= timeout_err_d;
         avg_en_q       <= avg_en_d;
         perturb_pos_q  <= perturb_pos_d;
         perturb_neg_q  <= perturb_neg_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign bus.AVG_EN       = avg_en_q;
   assign bus.PERTURB_POS  = perturb_pos_q;
   assign bus.PERTURB_NEG  = perturb_neg_q;
   assign bus.BUSY         = busy_q;
   assign bus.J_POS        = j_pos_q;
   assign bus.J_NEG        = j_neg_q;
   assign bus.DELTA_J      = delta_q;
   assign bus.RESULT_VALID = result_valid_q;
   assign bus.TIMEOUT_ERR  = timeout_err_q;

endmodule

// File: tb/tb_spgd_meas_sequencer.sv
// Bench for spgd_meas_sequencer: instance 0 (settle 4, timeout 4096) and
// instance 1 (settle 0, timeout 100) driven by model averagers.
module tb_spgd_meas_sequencer;

   typedef struct packed {
      logic        busy;
      logic        avg_en;
      logic        pp;
      logic        pn;
      logic        rv;
      logic        err;
      logic [11:0] jp;
      logic [11:0] jn;
      logic [12:0] dj;
   } obs_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   spgd_meas_sequencer_if #(.ADC_WIDTH(12)) bus_a ();
   spgd_meas_sequencer_if #(.ADC_WIDTH(12)) bus_b ();

   spgd_meas_sequencer #(
      .ADC_WIDTH(12), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(4096), .CNT_WIDTH(16)
   ) dut_a (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus_a)
   );

   spgd_meas_sequencer #(
      .ADC_WIDTH(12), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(100), .CNT_WIDTH(16)
   ) dut_b (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus_b)
   );

   int passes = 0;
   int checks = 0;

   logic        start_r [2];
   logic        abort_r [2];
   logic        man_done [2];
   logic [11:0] man_data [2];
   logic        resp_done [2];
   logic [11:0] resp_data [2];
   logic        resp_en [2];
   logic        resp_neg_en [2];
   int          resp_m [2];
   logic [11:0] resp_jp [2];
   logic [11:0] resp_jn [2];
   int          cnt [2];
   logic        prev_en [2];
   int          low_cnt [2];
   int          last_gap [2];
   int          excl [2];
   int          rv_cnt [2];
   logic [11:0] jpos_m [2];
   logic [11:0] jneg_m [2];

   assign bus_a.START    = start_r[0];
   assign bus_a.ABORT    = abort_r[0];
   assign bus_a.AVG_DONE = resp_done[0] | man_done[0];
   assign bus_a.AVG_DATA = man_done[0] ? man_data[0] : resp_data[0];
   assign bus_b.START    = start_r[1];
   assign bus_b.ABORT    = abort_r[1];
   assign bus_b.AVG_DONE = resp_done[1] | man_done[1];
   assign bus_b.AVG_DATA = man_done[1] ? man_data[1] : resp_data[1];

   obs_t oa, ob;
   assign oa = {bus_a.BUSY, bus_a.AVG_EN, bus_a.PERTURB_POS, bus_a.PERTURB_NEG,
                bus_a.RESULT_VALID, bus_a.TIMEOUT_ERR, bus_a.J_POS, bus_a.J_NEG, bus_a.DELTA_J};
   assign ob = {bus_b.BUSY, bus_b.AVG_EN, bus_b.PERTURB_POS, bus_b.PERTURB_NEG,
                bus_b.RESULT_VALID, bus_b.TIMEOUT_ERR, bus_b.J_POS, bus_b.J_NEG, bus_b.DELTA_J};

   function automatic obs_t obs(input int s);
      return (s != 0) ? ob : oa;
   endfunction

   function automatic int sx(input logic [11:0] v);
      return v[11] ? int'(v) - 4096 : int'(v);
   endfunction

   function automatic logic [12:0] exp_delta(input logic [11:0] jp, input logic [11:0] jn);
      return 13'(sx(jp) - sx(jn));
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
   endtask

   // Model averager: raises DONE for one cycle M cycles after AVG_EN rises.
   always @(negedge CLK) begin
      for (int s = 0; s < 2; s++) begin
         obs_t o;
         o = obs(s);
         if (o.avg_en) cnt[s] = cnt[s] + 1;
         else cnt[s] = 0;
         resp_done[s] = resp_en[s] && o.avg_en && (cnt[s] == resp_m[s] + 1)
                        && (o.pp || resp_neg_en[s]);
         resp_data[s] = o.pp ? resp_jp[s] : resp_jn[s];
         if (o.pp && o.pn) excl[s] = excl[s] + 1;
         if (o.rv) rv_cnt[s] = rv_cnt[s] + 1;
         if (o.avg_en) begin
            if (!prev_en[s] && o.pn) last_gap[s] = low_cnt[s];
            low_cnt[s] = 0;
         end else begin
            low_cnt[s] = low_cnt[s] + 1;
         end
         prev_en[s] = o.avg_en;
      end
   end

   // One full measurement; noise pulses START and AVG_DONE whenever they must be ignored.
   task automatic run(input int s, input logic [11:0] jp, input logic [11:0] jn,
                      input int m, input bit noise);
      int   e;
      int   settle;
      obs_t o;
      settle = (s != 0) ? 1 : 4;
      resp_jp[s] = jp;
      resp_jn[s] = jn;
      resp_m[s]  = m;
      last_gap[s] = -1;
      @(negedge CLK);
      start_r[s] = 1'b1;
      e = -1;
      do begin
         @(posedge CLK);
         e++;
         @(negedge CLK);
         o = obs(s);
         start_r[s]  = noise && o.busy && !o.avg_en && !o.rv;
         man_done[s] = start_r[s];
         man_data[s] = 12'($urandom);
      end while (!o.rv && e < 20000);
      start_r[s]  = 1'b0;
      man_done[s] = 1'b0;
      jpos_m[s] = jp;
      jneg_m[s] = jn;
      chk($sformatf("lat_%0d", s), 64'(e), 64'(2 * settle + 2 * m + 2));
      chk($sformatf("jpos_%0d", s), 64'(o.jp), 64'(jp));
      chk($sformatf("jneg_%0d", s), 64'(o.jn), 64'(jn));
      chk($sformatf("delta_%0d", s), 64'(o.dj), 64'(exp_delta(jp, jn)));
      chk($sformatf("gap_%0d", s), 64'(last_gap[s]), 64'(settle));
      @(negedge CLK);
      o = obs(s);
      chk($sformatf("after_rv_%0d", s), 64'({o.rv, o.busy}), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          e;
      int          lows;
      int          rv0;
      logic [11:0] jp;
      logic [11:0] jn;
      obs_t        o;

      for (int s = 0; s < 2; s++) begin
         start_r[s] = 0; abort_r[s] = 0; man_done[s] = 0; man_data[s] = '0;
         resp_done[s] = 0; resp_data[s] = '0; resp_en[s] = 1; resp_neg_en[s] = 1;
         resp_m[s] = 1; resp_jp[s] = '0; resp_jn[s] = '0; cnt[s] = 0; prev_en[s] = 0;
         low_cnt[s] = 0; last_gap[s] = -1; excl[s] = 0; rv_cnt[s] = 0;
         jpos_m[s] = '0; jneg_m[s] = '0;
      end

      repeat (3) @(negedge CLK);
      chk("reset_a", 64'(oa), 64'(0));
      chk("reset_b", 64'(ob), 64'(0));
      RST_N = 1'b1;

      // Nominal run and signed extremes
      run(0, 12'h100, 12'h0F0, 1025, 1'b0);
      chk("nominal_delta_16", 64'(oa.dj), 64'(13'd16));
      run(0, 12'h800, 12'h7FF, 3, 1'b0);
      chk("extreme_delta", 64'(oa.dj), 64'(13'h1001));

      for (int i = 0; i < 5; i++) begin
         run(0, 12'($urandom), 12'($urandom), int'($urandom_range(1, 12)), 1'b0);
      end

      // START while busy and AVG_DONE outside MEAS states must change nothing
      run(0, 12'($urandom), 12'($urandom), int'($urandom_range(2, 8)), 1'b1);

      // ABORT together with AVG_DONE in MEAS_NEG
      resp_neg_en[0] = 1'b0;
      jp = 12'($urandom);
      resp_jp[0] = jp;
      resp_m[0]  = 3;
      rv0 = rv_cnt[0];
      @(negedge CLK); start_r[0] = 1'b1;
      @(negedge CLK); start_r[0] = 1'b0;
      e = 0;
      while (!(oa.avg_en && oa.pn) && e < 200) begin @(negedge CLK); e++; end
      chk("abort_reach_meas_neg", 64'({oa.avg_en, oa.pn}), 64'(2'b11));
      man_data[0] = 12'($urandom); man_done[0] = 1'b1; abort_r[0] = 1'b1;
      @(negedge CLK);
      man_done[0] = 1'b0; abort_r[0] = 1'b0;
      chk("abort_outputs_low", 64'({oa.busy, oa.avg_en, oa.pp, oa.pn, oa.rv}), 64'(0));
      chk("abort_jneg_kept", 64'(oa.jn), 64'(jneg_m[0]));
      chk("abort_jpos_captured", 64'(oa.jp), 64'(jp));
      jpos_m[0] = jp;
      repeat (3) @(negedge CLK);
      chk("abort_no_rv", 64'(rv_cnt[0] - rv0), 64'(0));
      resp_neg_en[0] = 1'b1;

      // START held high: back-to-back runs with a single IDLE cycle between
      resp_jp[0] = 12'h123; resp_jn[0] = 12'h021; resp_m[0] = 2;
      @(negedge CLK); start_r[0] = 1'b1;
      e = 0;
      while (!oa.rv && e < 500) begin @(negedge CLK); e++; end
      chk("b2b_first_delta", 64'(oa.dj), 64'(exp_delta(12'h123, 12'h021)));
      resp_jp[0] = 12'hF00; resp_jn[0] = 12'h0FF;
      lows = 0; e = 0;
      do begin
         @(negedge CLK); e++;
         if (!oa.busy) lows++;
      end while (!(oa.busy && lows > 0) && e < 50);
      start_r[0] = 1'b0;
      chk("b2b_idle_cycles", 64'(lows), 64'(1));
      e = 0;
      while (!oa.rv && e < 500) begin @(negedge CLK); e++; end
      chk("b2b_second_delta", 64'(oa.dj), 64'(exp_delta(12'hF00, 12'h0FF)));
      jpos_m[0] = 12'hF00; jneg_m[0] = 12'h0FF;

      // Asynchronous reset in the middle of SET_NEG
      resp_jp[0] = 12'h5A5; resp_m[0] = 5;
      @(negedge CLK); start_r[0] = 1'b1;
      @(negedge CLK); start_r[0] = 1'b0;
      e = 0;
      while (!(oa.pn && !oa.avg_en) && e < 200) begin @(negedge CLK); e++; end
      chk("rst_pre_jpos", 64'(oa.jp), 64'(12'h5A5));
      #2 RST_N = 1'b0;
      #1 chk("async_reset_outputs", 64'(oa), 64'(0));
      jpos_m[0] = '0; jneg_m[0] = '0;
      @(negedge CLK); RST_N = 1'b1;
      @(negedge CLK);
      chk("post_reset_idle", 64'(oa), 64'(0));

      // Settle of 0 behaves as 1 (single low AVG_EN cycle between windows)
      run(1, 12'($urandom), 12'($urandom), int'($urandom_range(1, 20)), 1'b0);
      run(1, 12'($urandom), 12'($urandom), int'($urandom_range(1, 20)), 1'b0);

      // Timeout: no AVG_DONE in MEAS_POS
      resp_en[1] = 1'b0;
      rv0 = rv_cnt[1];
      @(negedge CLK); start_r[1] = 1'b1;
      @(negedge CLK); start_r[1] = 1'b0;
      e = 0;
      while (!ob.avg_en && e < 50) begin @(negedge CLK); e++; end
      e = 0;
      do begin
         @(posedge CLK); e++;
         @(negedge CLK);
      end while (!ob.err && e < 300);
      chk("timeout_latency", 64'(e), 64'(100));
      chk("timeout_idle", 64'({ob.busy, ob.avg_en, ob.pp, ob.pn}), 64'(0));
      chk("timeout_jpos_kept", 64'(ob.jp), 64'(jpos_m[1]));
      chk("timeout_jneg_kept", 64'(ob.jn), 64'(jneg_m[1]));
      repeat (3) @(negedge CLK);
      chk("timeout_no_rv", 64'(rv_cnt[1] - rv0), 64'(0));
      chk("timeout_sticky", 64'(ob.err), 64'(1));
      resp_en[1] = 1'b1;
      run(1, 12'($urandom), 12'($urandom), int'($urandom_range(1, 20)), 1'b0);
      chk("timeout_cleared", 64'(ob.err), 64'(0));

      chk("exclusive_a", 64'(excl[0]), 64'(0));
      chk("exclusive_b", 64'(excl[1]), 64'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
